// File: rtl/prog_host_seq.sv
// prog_host_seq: host-side run sequencer for the processor core.
// Preloads operands into data memory, pulses req, waits for done (with a
// timeout), then streams result bytes back out of data memory.
// Optional result checksum: define HOST_XSUM_EN to build the xsum accumulator;
// without it xsum is tied to zero.
//
// state  | meaning
// -------+-----------------------------------------------------
// IDLE   | waiting for start
// LOAD   | accepting preload beats and writing data memory
// REQ    | holding req high for REQ_CYC cycles
// WAIT   | waiting for done or the timeout
// READ   | streaming result bytes out of data memory
// FIN    | one-cycle completion pulse
module prog_host_seq #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_LEN   = 32,
  parameter int REQ_CYC   = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat,
  output logic          req,
  input  logic          done,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  input  logic          res_ready,
  output logic          busy,
  output logic          fin,
  output logic          timeout_err,
  output logic [15:0]   run_cycles,
  output logic [DW-1:0] xsum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_READ,
    S_FIN
  } state_t;

  localparam logic [15:0]   LD_LAST  = 16'(LOAD_LEN - 1);
  localparam logic [15:0]   RES_LAST = 16'(RES_LEN - 1);
  localparam logic [15:0]   REQ_LAST = 16'(REQ_CYC - 1);
  localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [AW-1:0] LD_BASE_A  = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RES_BASE_A = AW'(RES_BASE);

  state_t      state;
  logic [15:0] idx;
  logic [15:0] cnt;

  // Sequencer: state, beat index, phase counter and run status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      run_cycles  <= '0;
`ifdef HOST_XSUM_EN
      xsum        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx         <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
            run_cycles  <= '0;
`ifdef HOST_XSUM_EN
            xsum        <= '0;
`endif
            state       <= (LOAD_LEN == 0) ? S_REQ : S_LOAD;
          end
        end
        S_LOAD: begin
          // ld_ready is high for the whole state, so a beat is just ld_valid.
          if (ld_valid) begin
            if (idx == LD_LAST) begin
              idx   <= '0;
              cnt   <= '0;
              state <= S_REQ;
            end else begin
              idx <= idx + 16'd1;
            end
          end
        end
        S_REQ: begin
          if (cnt == REQ_LAST) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WAIT: begin
          if (run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
          // done is checked first so a done landing on the last timeout
          // cycle still counts as a good run.
          if (done) begin
            idx   <= '0;
            state <= (RES_LEN == 0) ? S_FIN : S_READ;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_FIN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_READ: begin
          if (res_ready) begin
`ifdef HOST_XSUM_EN
            xsum <= xsum ^ mem_rdat;
`endif
            if (idx == RES_LAST) begin
              state <= S_FIN;
            end else begin
              idx <= idx + 16'd1;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef HOST_XSUM_EN
  assign xsum = '0;
`endif

  // Memory port and handshake outputs decoded from the registered state.
  always_comb begin
    ld_ready  = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdat  = '0;
    req       = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    busy      = (state != S_IDLE);
    fin       = (state == S_FIN);
    case (state)
      S_LOAD: begin
        ld_ready  = 1'b1;
        mem_wr_en = ld_valid;
        mem_addr  = LD_BASE_A + AW'(idx);
        mem_wdat  = ld_data;
      end
      S_REQ: begin
        req = 1'b1;
      end
      S_READ: begin
        mem_addr  = RES_BASE_A + AW'(idx);
        res_valid = 1'b1;
        res_data  = mem_rdat;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/prog_host_seq.md
Name: prog_host_seq

Overview:
- Initiator side of the processor's req/done run handshake, and the external owner of the data-memory port.
- Per run, in order:
  - Preloads a block of operands into data memory from an input stream.
  - Pulses req to launch the core.
  - Waits for done, or times out.
  - Streams a block of result bytes back out of data memory.
- Sits between the test harness (or host interface) and the core's top level, driving the data memory's write/read side while the core is idle.

Parameters:
- AW, 8, data-memory address width
- DW, 8, data word width
- LOAD_BASE, 0, first preload address
- LOAD_LEN, 64, preload beat count (0 = skip LOAD)
- RES_BASE, 64, first result address
- RES_LEN, 32, result beat count (0 = skip READ)
- REQ_CYC, 2, cycles req is held high
- TIMEOUT, 4096, maximum WAIT cycles before abort

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled in IDLE only
- ld_valid  in  1  preload beat valid
- ld_data  in  DW  preload byte
- ld_ready  out  1  preload beat accepted
- mem_wr_en  out  1  data-memory write enable
- mem_addr  out  AW  data-memory address
- mem_wdat  out  DW  data-memory write data
- mem_rdat  in  DW  data-memory read data (combinational read)
- req  out  1  run request to core
- done  in  1  core finished (level)
- res_valid  out  1  result beat valid
- res_data  out  DW  result byte
- res_ready  in  1  result consumer ready
- busy  out  1  state != IDLE
- fin  out  1  one-cycle pulse at run end
- timeout_err  out  1  sticky, last run timed out
- run_cycles  out  16  WAIT-state cycle count, saturating
- xsum  out  DW  result checksum (see Optional Feature)

Behaviour:
- States: IDLE, LOAD, REQ, WAIT, READ, FIN. A 16-bit beat index idx and a 16-bit counter cnt are registered.
- Reset (async, any state, including mid-run) forces IDLE and zeroes idx, cnt, run_cycles, timeout_err and xsum. All outputs are 0 during reset.
- IDLE:
  - start=1: idx←0, timeout_err←0, run_cycles←0, xsum←0.
  - Next state is LOAD, or REQ if LOAD_LEN=0.
  - start in any other state is ignored.
- LOAD:
  - ld_ready=1.
  - mem_wr_en = ld_valid, combinational.
  - mem_addr = LOAD_BASE+idx, mod 2^AW (wraps).
  - mem_wdat = ld_data.
  - Each beat (ld_valid & ld_ready) increments idx. On beat LOAD_LEN-1: idx←0, cnt←0, next state REQ.
  - A ld_valid gap stalls with no write.
- REQ: req=1 for exactly REQ_CYC cycles (counted by cnt), then WAIT with cnt←0. done is ignored while req=1.
- WAIT:
  - req=0, mem_wr_en=0.
  - Each cycle, run_cycles increments, saturating at 0xFFFF.
  - done=1 → READ (or FIN if RES_LEN=0), idx←0.
  - cnt reaches TIMEOUT-1 with done=0 → timeout_err←1, then FIN; READ is skipped.
  - done and timeout in the same cycle: done wins, no error.
- READ:
  - mem_addr = RES_BASE+idx, mod 2^AW.
  - res_valid=1, res_data = mem_rdat.
  - Each beat (res_valid & res_ready) increments idx. res_addr/res_data hold stable while res_ready=0.
  - On beat RES_LEN-1 → FIN.
- FIN: fin=1 for one cycle, then IDLE. timeout_err and run_cycles hold until the next start.
- Outside LOAD, mem_wr_en=0. Outside LOAD/READ, mem_addr=0.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro HOST_XSUM_EN.
- Defined: xsum ← xsum XOR res_data on every READ beat, cleared at start, holds after FIN.
- Undefined: xsum is tied to 0 and no accumulator is built.

Test Plan:
- LOAD_LEN=4, RES_LEN=2. Preload 11,22,33,44 with ld_valid held high; the core model asserts done 10 cycles after req falls and memory holds 0xA5,0x5A at 64/65 → writes at addresses 0-3 on 4 consecutive cycles; req high 2 cycles; run_cycles=11; res_data 0xA5 then 0x5A; fin one cycle; xsum=0xFF when enabled.
- Toggle ld_valid 1,0,1,0 during LOAD → writes occur only on valid cycles, addresses stay contiguous, REQ entered after the 4th beat.
- Hold res_ready=0 for 3 cycles on beat 0 → res_data/mem_addr stable at 0xA5/64 throughout; 2 beats total.
- done never asserted, TIMEOUT=16 → FIN after 16 WAIT cycles; timeout_err=1; no res_valid. A next start clears timeout_err.
- LOAD_BASE=254, LOAD_LEN=4 → write addresses 254,255,0,1.
- Assert reset during WAIT → immediate IDLE; req, busy and fin are 0; a start after reset runs a full sequence normally.
